// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: payload/tag widths and entry layout.
// Used by dispatch and by every RS instance.
package rs_pkg;

  localparam int DATA_W = 76;
  localparam int TAG_W  = 6;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  src1_tag;
    logic              src1_rdy;
    logic [TAG_W-1:0]  src2_tag;
    logic              src2_rdy;
  } rs_entry_t;

endpackage

// File: rtl/rs_wakeup_cmp.sv
// Tag comparator: flags a source tag that matches either valid CDB broadcast.
module rs_wakeup_cmp #(
  parameter int TAG_W = 6
) (
  input  logic [TAG_W-1:0] src_tag,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  output logic             match
);

  // Both ports may hit the same operand; OR-ing keeps that harmless.
  always_comb begin
    match = (cdb0_valid && (cdb0_tag == src_tag)) ||
            (cdb1_valid && (cdb1_tag == src_tag));
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Collapsing-queue reservation station. Index 0 holds the oldest entry and
// valid entries are always packed into 0..count-1, so oldest-ready select is
// a simple lowest-index priority pick and removal is a shift-down.
module rs_issue_scheduler
  import rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  // Entry storage uses rs_entry_t, so these must match the package widths.
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int TAG_W  = rs_pkg::TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           in_src1_tag,
  input  logic                       in_src1_rdy,
  input  logic [TAG_W-1:0]           in_src2_tag,
  input  logic                       in_src2_rdy,
  output logic                       rs_empty,
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  input  logic                       cdb0_valid,
  input  logic [TAG_W-1:0]           cdb0_tag,
  input  logic                       cdb1_valid,
  input  logic [TAG_W-1:0]           cdb1_tag,
  output logic                       issue_valid,
  output logic [DATA_W-1:0]          issue_data,
  input  logic                       issue_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_n [DEPTH];
  // One spare slot past the top so the shift-down reads an empty entry.
  rs_entry_t        woke  [DEPTH+1];
  rs_entry_t        new_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             alloc;
  logic             issue_fire;
  logic [DEPTH-1:0] ent_m1;
  logic [DEPTH-1:0] ent_m2;
  logic             in_m1;
  logic             in_m2;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent_cmp
      rs_wakeup_cmp #(.TAG_W(TAG_W)) u_cmp_s1 (
        .src_tag    (ent_q[g].src1_tag),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .match      (ent_m1[g])
      );
      rs_wakeup_cmp #(.TAG_W(TAG_W)) u_cmp_s2 (
        .src_tag    (ent_q[g].src2_tag),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .match      (ent_m2[g])
      );
    end
  endgenerate

  // Bypass comparators catch a broadcast landing in the same cycle as dispatch.
  rs_wakeup_cmp #(.TAG_W(TAG_W)) u_cmp_in1 (
    .src_tag    (in_src1_tag),
    .cdb0_valid (cdb0_valid),
    .cdb0_tag   (cdb0_tag),
    .cdb1_valid (cdb1_valid),
    .cdb1_tag   (cdb1_tag),
    .match      (in_m1)
  );
  rs_wakeup_cmp #(.TAG_W(TAG_W)) u_cmp_in2 (
    .src_tag    (in_src2_tag),
    .cdb0_valid (cdb0_valid),
    .cdb0_tag   (cdb0_tag),
    .cdb1_valid (cdb1_valid),
    .cdb1_tag   (cdb1_tag),
    .match      (in_m2)
  );

  // Free-slot flag comes from the registered count only.
  always_comb begin
    rs_count = count_q;
    rs_empty = (count_q < CNT_W'(DEPTH));
  end

  // Oldest-ready select: scan from the top so the lowest ready index wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Issue port driven purely from registered state.
  always_comb begin
    issue_valid = sel_found;
    issue_data  = sel_found ? ent_q[sel_idx].data : '0;
    issue_fire  = sel_found && issue_ready;
    alloc       = in_valid && rs_empty;
    alloc_idx   = count_q - CNT_W'(issue_fire);
  end

  // Next entry state: wakeup, collapse above the issued slot, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].valid) begin
        woke[i].src1_rdy = ent_q[i].src1_rdy | ent_m1[i];
        woke[i].src2_rdy = ent_q[i].src2_rdy | ent_m2[i];
      end
    end
    woke[DEPTH] = '0;

    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.data     = in_data;
    new_ent.src1_tag = in_src1_tag;
    new_ent.src1_rdy = in_src1_rdy | in_m1;
    new_ent.src2_tag = in_src2_tag;
    new_ent.src2_rdy = in_src2_rdy | in_m2;

    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        ent_n[i] = woke[i+1];
      end else begin
        ent_n[i] = woke[i];
      end
      if (alloc && (alloc_idx == CNT_W'(i))) begin
        ent_n[i] = new_ent;
      end
    end

    count_n = count_q + CNT_W'(alloc) - CNT_W'(issue_fire);

    // Flush beats everything else in the same cycle.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_n[i] = '0;
      end
      count_n = '0;
    end
  end

  // State registers with async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_n[i];
      end
      count_q <= count_n;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: allocation, full-queue blocking,
// wakeup/bypass, age-ordered select, collapse on issue, flush and reset.
module tb_rs_issue_scheduler;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 76;
  localparam int TAG_W  = 6;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_src1_tag;
  logic              in_src1_rdy;
  logic [TAG_W-1:0]  in_src2_tag;
  logic              in_src2_rdy;
  logic              rs_empty;
  logic [CNT_W-1:0]  rs_count;
  logic              cdb0_valid;
  logic [TAG_W-1:0]  cdb0_tag;
  logic              cdb1_valid;
  logic [TAG_W-1:0]  cdb1_tag;
  logic              issue_valid;
  logic [DATA_W-1:0] issue_data;
  logic              issue_ready;

  int n_assert = 0;
  int n_fail   = 0;

  rs_issue_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_src1_tag (in_src1_tag),
    .in_src1_rdy (in_src1_rdy),
    .in_src2_tag (in_src2_tag),
    .in_src2_rdy (in_src2_rdy),
    .rs_empty    (rs_empty),
    .rs_count    (rs_count),
    .cdb0_valid  (cdb0_valid),
    .cdb0_tag    (cdb0_tag),
    .cdb1_valid  (cdb1_valid),
    .cdb1_tag    (cdb1_tag),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .issue_ready (issue_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    issue_ready = 1'b0;
    cdb0_valid  = 1'b0;
    cdb1_valid  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic dispatch(input logic [DATA_W-1:0] d,
                          input logic [TAG_W-1:0] t1, input logic r1,
                          input logic [TAG_W-1:0] t2, input logic r2);
    in_valid    = 1'b1;
    in_data     = d;
    in_src1_tag = t1;
    in_src1_rdy = r1;
    in_src2_tag = t2;
    in_src2_rdy = r2;
  endtask

  // One clock: inputs set before the call are seen at the edge, then cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    in_src1_tag = '0;
    in_src1_rdy = 1'b0;
    in_src2_tag = '0;
    in_src2_rdy = 1'b0;
    cdb0_tag    = '0;
    cdb1_tag    = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", 128'(rs_empty), 128'(1));
    chk("reset_count", 128'(rs_count), 128'(0));
    chk("reset_ivalid", 128'(issue_valid), 128'(0));
    chk("reset_idata", 128'(issue_data), 128'(0));
    rst = 1'b0;

    // Fill with four ready entries, FU not accepting.
    for (int i = 0; i < 4; i++) begin
      dispatch(DATA_W'(76'h1000 + i), 6'd0, 1'b1, 6'd0, 1'b1);
      tick();
    end
    chk("fill_count", 128'(rs_count), 128'(4));
    chk("fill_empty", 128'(rs_empty), 128'(0));
    chk("fill_ivalid", 128'(issue_valid), 128'(1));
    chk("fill_idata", 128'(issue_data), 128'(76'h1000));

    // Dispatch into a full RS is dropped.
    dispatch(76'hAA, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("full_drop_count", 128'(rs_count), 128'(4));
    chk("full_drop_idata", 128'(issue_data), 128'(76'h1000));

    issue_ready = 1'b1;
    tick();
    chk("issue1_count", 128'(rs_count), 128'(3));
    chk("issue1_empty", 128'(rs_empty), 128'(1));
    chk("issue1_idata", 128'(issue_data), 128'(76'h1001));
    for (int i = 0; i < 3; i++) begin
      issue_ready = 1'b1;
      tick();
    end
    chk("drain_count", 128'(rs_count), 128'(0));
    chk("drain_ivalid", 128'(issue_valid), 128'(0));
    chk("drain_idata", 128'(issue_data), 128'(0));

    // Younger ready entry overtakes an older waiting one.
    dispatch(76'hA, 6'd5, 1'b0, 6'd0, 1'b1);
    tick();
    chk("a_wait_ivalid", 128'(issue_valid), 128'(0));
    chk("a_wait_count", 128'(rs_count), 128'(1));
    dispatch(76'hB, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("b_count", 128'(rs_count), 128'(2));
    chk("b_first_idata", 128'(issue_data), 128'(76'hB));
    issue_ready = 1'b1;
    cdb1_valid  = 1'b1;
    cdb1_tag    = 6'd4;
    tick();
    chk("b_issued_count", 128'(rs_count), 128'(1));
    chk("wrong_tag_ivalid", 128'(issue_valid), 128'(0));
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd5;
    tick();
    chk("a_woke_ivalid", 128'(issue_valid), 128'(1));
    chk("a_woke_idata", 128'(issue_data), 128'(76'hA));
    issue_ready = 1'b1;
    tick();
    chk("a_issued_count", 128'(rs_count), 128'(0));

    // Same-cycle bypass on src2 from CDB1.
    dispatch(76'hC, 6'd0, 1'b1, 6'd9, 1'b0);
    cdb1_valid = 1'b1;
    cdb1_tag   = 6'd9;
    tick();
    chk("bypass_count", 128'(rs_count), 128'(1));
    chk("bypass_ivalid", 128'(issue_valid), 128'(1));
    chk("bypass_idata", 128'(issue_data), 128'(76'hC));
    dispatch(76'hD, 6'd3, 1'b0, 6'd3, 1'b0);
    issue_ready = 1'b1;
    tick();
    chk("d_alloc_issue_count", 128'(rs_count), 128'(1));
    chk("d_wait_ivalid", 128'(issue_valid), 128'(0));
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd3;
    cdb1_valid = 1'b1;
    cdb1_tag   = 6'd3;
    tick();
    chk("dual_cdb_idata", 128'(issue_data), 128'(76'hD));
    issue_ready = 1'b1;
    tick();
    chk("d_issued_count", 128'(rs_count), 128'(0));

    // Allocate and issue in one cycle at count 2; age order kept.
    dispatch(76'hE, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    dispatch(76'hF, 6'd12, 1'b0, 6'd0, 1'b1);
    tick();
    chk("ef_count", 128'(rs_count), 128'(2));
    chk("ef_idata", 128'(issue_data), 128'(76'hE));
    dispatch(76'h6, 6'd0, 1'b1, 6'd0, 1'b1);
    issue_ready = 1'b1;
    tick();
    chk("alloc_issue_count", 128'(rs_count), 128'(2));
    chk("alloc_issue_idata", 128'(issue_data), 128'(76'h6));
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd12;
    tick();
    chk("order_f_first", 128'(issue_data), 128'(76'hF));
    issue_ready = 1'b1;
    tick();
    chk("f_issued_count", 128'(rs_count), 128'(1));
    chk("f_issued_idata", 128'(issue_data), 128'(76'h6));

    // Flush at count 3 overrides a same-cycle dispatch and issue.
    dispatch(76'h11, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    dispatch(76'h12, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("pre_flush_count", 128'(rs_count), 128'(3));
    dispatch(76'h5A, 6'd0, 1'b1, 6'd0, 1'b1);
    issue_ready = 1'b1;
    flush       = 1'b1;
    tick();
    chk("flush_count", 128'(rs_count), 128'(0));
    chk("flush_empty", 128'(rs_empty), 128'(1));
    chk("flush_ivalid", 128'(issue_valid), 128'(0));
    chk("flush_idata", 128'(issue_data), 128'(0));

    // Full RS with simultaneous dispatch and issue: dispatch dropped.
    for (int i = 0; i < 4; i++) begin
      dispatch(DATA_W'(76'h2000 + i), 6'd0, 1'b1, 6'd0, 1'b1);
      tick();
    end
    chk("refill_count", 128'(rs_count), 128'(4));
    dispatch(76'hEE, 6'd0, 1'b1, 6'd0, 1'b1);
    issue_ready = 1'b1;
    tick();
    chk("full_issue_count", 128'(rs_count), 128'(3));
    chk("full_issue_empty", 128'(rs_empty), 128'(1));
    chk("full_issue_idata", 128'(issue_data), 128'(76'h2001));
    dispatch(76'hEF, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("freed_slot_count", 128'(rs_count), 128'(4));

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 128'(rs_count), 128'(0));
    chk("async_rst_empty", 128'(rs_empty), 128'(1));
    chk("async_rst_ivalid", 128'(issue_valid), 128'(0));
    chk("async_rst_idata", 128'(issue_data), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    dispatch(76'h77, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("post_rst_count", 128'(rs_count), 128'(1));
    chk("post_rst_idata", 128'(issue_data), 128'(76'h77));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Collapsing-queue reservation station with issue scheduler, one instance per execution slot (complex_0/1, simple_0/1, fp_0/1). Accepts one instruction per cycle from dispatch, tracks operand readiness via two CDB broadcast ports, and issues the oldest ready entry to its functional unit over a valid/ready handshake. Drives the per-RS empty flag that dispatch uses for steering and stall.

Parameters:
DEPTH, 4, number of RS entries (2..8)
DATA_W, 76, opaque instruction payload width, matches dispatch output
TAG_W, 6, physical register / ROB tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous squash of all entries
in_valid  in  1  dispatch writes an instruction this cycle
in_data  in  DATA_W  instruction payload
in_src1_tag  in  TAG_W  source 1 producer tag
in_src1_rdy  in  1  source 1 already available
in_src2_tag  in  TAG_W  source 2 producer tag
in_src2_rdy  in  1  source 2 already available
rs_empty  out  1  at least one free entry (dispatch's *_empty input)
rs_count  out  $clog2(DEPTH+1)  occupied entries
cdb0_valid  in  1  broadcast 0 valid
cdb0_tag  in  TAG_W  broadcast 0 tag
cdb1_valid  in  1  broadcast 1 valid
cdb1_tag  in  TAG_W  broadcast 1 tag
issue_valid  out  1  an entry is ready to issue
issue_data  out  DATA_W  payload of selected entry
issue_ready  in  1  FU accepts this cycle

Behaviour:
- Reset (async, rst=1): all entry valid bits 0, count 0; rs_empty=1, rs_count=0, issue_valid=0, issue_data=0.
- Storage per entry: valid, data, src1_tag, src1_rdy, src2_tag, src2_rdy. Entries are age-ordered; index 0 is oldest; valid entries occupy contiguous indices 0..count-1.
- rs_empty = (count < DEPTH), driven from registered count (no combinational path from in_valid).
- Allocate: on in_valid && rs_empty, write at index count (count-1 if an issue fires the same cycle). in_valid while rs_empty=0 is ignored; no state change.
- Wakeup: on each edge, any valid entry whose src tag equals a valid CDB tag sets that rdy bit. Same-cycle bypass: an incoming instruction whose src tag matches a valid CDB tag is stored as ready. Both CDBs may match the same entry/operand; result is still rdy=1.
- Select: issue_valid = OR over entries of (valid & src1_rdy & src2_rdy); pick the lowest such index. issue_data = that entry's data, zero when issue_valid=0. Combinational from registered state only; an entry woken at edge t issues no earlier than cycle t.
- Issue: on issue_valid && issue_ready, the selected entry is removed at the edge and all younger entries shift down one index, preserving age order. No hold requirement: selection may change between cycles if an older entry becomes ready.
- Count: +1 on accepted allocate, -1 on issue, unchanged when both occur; never exceeds DEPTH or goes below 0.
- Full + simultaneous issue: rs_empty was 0, so no allocate that cycle; the freed slot is visible next cycle.
- Flush: priority over allocate, issue and wakeup. All valid bits clear at the edge, count=0; issue_valid=0 the following cycle. issue_valid may still be 1 combinationally in the flush cycle; a handshake in that cycle is ignored by the FU by protocol.
- Reset mid-operation: immediate return to reset state; in-flight contents discarded.

Decomposition:
- Shared package rs_pkg: DATA_W, TAG_W, and the rs_entry_t layout (valid, data, src tags, rdy bits). This package is also used by dispatch and other RS instances.
- One sub-module, rs_wakeup_cmp: compares a src tag against both CDB ports and returns match. Instantiated 2×DEPTH + 2 times (entries plus bypass).

Test Plan:
1. Reset, then 4 allocates with rdy=1/1, issue_ready=0 -> rs_count=4, rs_empty=0, issue_valid=1, issue_data=entry0 payload.
2. Full RS, in_valid=1 with payload 0xAA -> ignored; count stays 4. Then issue_ready=1 for one cycle -> count=3, rs_empty=1, entry1 becomes index 0.
3. Allocate A (src1_tag=5, rdy=0) then B (ready) -> B issues first; cdb0 tag=5 -> A issue_valid=1 the next cycle.
4. in_valid with src2_tag=9, rdy=0, and cdb1_valid tag=9 in the same cycle -> entry stored ready; issue_valid=1 next cycle.
5. count=2, allocate + issue in the same cycle -> count stays 2; new entry at index 1; order preserved.
6. count=3, flush=1 with in_valid=1 -> count=0, rs_empty=1, issue_valid=0 next cycle. rst pulsed mid-stream -> same result asynchronously.
